// File: rtl/ela_row_sched_if.sv
// Row scheduler bus bundle: host pixel fetch, ELA datapath line-buffer/request/result
// signals, result-memory write port and frame status.
// master = scheduler side, slave = host/datapath/memory side. stall_cnt exists only
// when ELA_STALL_CNT_EN is defined.
interface ela_row_sched_if #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 31
);
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ADDR_W = $clog2(IMG_W * IMG_H);

  logic              req;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              dp_load;
  logic [7:0]        dp_pix;
  logic              dp_line_end;
  logic              dp_start;
  logic [COL_W-1:0]  dp_col;
  logic              dp_res_valid;
  logic [7:0]        dp_res;
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_wr;
  logic              done;
  logic              err;
`ifdef ELA_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  modport master (
`ifdef ELA_STALL_CNT_EN
    output stall_cnt,
`endif
    output req, dp_load, dp_pix, dp_line_end, dp_start, dp_col,
    output wen, addr, data_wr, done, err,
    input  in_valid, in_data, dp_res_valid, dp_res
  );

  modport slave (
`ifdef ELA_STALL_CNT_EN
    input  stall_cnt,
`endif
    input  req, dp_load, dp_pix, dp_line_end, dp_start, dp_col,
    input  wen, addr, data_wr, done, err,
    output in_valid, in_data, dp_res_valid, dp_res
  );
endinterface

// File: rtl/ela_row_sched.sv
// ELA deinterlacer row scheduler: loads even rows from the host into result memory and
// the datapath line buffers, then requests/writes back the interpolated odd row between
// each pair of loaded even rows, ending in a sticky done.
// Ports: clk, rst (async active-high), bus (ela_row_sched_if.master). All outputs are
// registered. Optional ELA_STALL_CNT_EN adds bus.stall_cnt (saturating stall counter).
module ela_row_sched #(
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 31,
  parameter int MAX_OUTST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  ela_row_sched_if.master        bus
);
  localparam int COL_W  = $clog2(IMG_W);
  localparam int CNT_W  = COL_W + 1;
  localparam int ADDR_W = $clog2(IMG_W * IMG_H);
  localparam int ROW_W  = $clog2(IMG_H + 3);
  localparam logic [CNT_W-1:0] W_CNT       = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] LAST_COL    = CNT_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_INTERP = ROW_W'(IMG_H - 2);
  localparam logic [3:0]       MAX_O       = 4'(MAX_OUTST);

  typedef enum logic [1:0] {IDLE, LOAD, INTERP, FIN} state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  col_q, col_d, ic_q, ic_d, rc_q, rc_d;
  logic [3:0]        outst_q, outst_d;

  logic              req_d, dp_load_d, dp_line_end_d, dp_start_d, wen_d, done_d, err_d;
  logic [7:0]        dp_pix_d, data_wr_d;
  logic [COL_W-1:0]  dp_col_d;
  logic [ADDR_W-1:0] addr_d;

  logic accept, issue, res_ok, res_bad, row_done;

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [ROW_W-1:0] r,
                                                input logic [CNT_W-1:0] c);
    return (ADDR_W'(r) << COL_W) | ADDR_W'(c[COL_W-1:0]);
  endfunction

  assign accept  = (state_q == LOAD) && bus.req && bus.in_valid;
  assign issue   = (state_q == INTERP) && (ic_q < W_CNT) && (outst_q < MAX_O);
  assign res_ok  = bus.dp_res_valid && (state_q == INTERP) && (outst_q != 4'd0);
  assign res_bad = bus.dp_res_valid && !res_ok;
  // A row finishes one cycle after its last pixel write is issued, so done
  // (and the next row's req) appear strictly after the final write.
  assign row_done = ((state_q == LOAD) && (col_q == W_CNT)) ||
                    ((state_q == INTERP) && (rc_q == W_CNT));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Next-state: LOAD 0, LOAD 2, INTERP 1, LOAD 4, INTERP 3, ... INTERP IMG_H-2, FIN
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        state_d = LOAD;
        row_d   = '0;
      end
      LOAD: if (row_done) begin
        if (row_q == '0) begin
          row_d = ROW_W'(2);
        end else begin
          state_d = INTERP;
          row_d   = row_q - ROW_W'(1);
        end
      end
      INTERP: if (row_done) begin
        if (row_q == LAST_INTERP) begin
          state_d = FIN;
        end else begin
          state_d = LOAD;
          row_d   = row_q + ROW_W'(3);
        end
      end
      default: ;
    endcase
  end

  // Output/counter next values
  always_comb begin
    col_d         = col_q;
    ic_d          = ic_q;
    rc_d          = rc_q;
    outst_d       = outst_q;
    dp_load_d     = 1'b0;
    dp_line_end_d = 1'b0;
    dp_start_d    = 1'b0;
    wen_d         = 1'b0;
    dp_pix_d      = bus.dp_pix;
    dp_col_d      = bus.dp_col;
    addr_d        = bus.addr;
    data_wr_d     = bus.data_wr;
    if (row_done) begin
      col_d   = '0;
      ic_d    = '0;
      rc_d    = '0;
      outst_d = '0;
    end else begin
      if (accept) begin
        col_d         = col_q + CNT_W'(1);
        wen_d         = 1'b1;
        addr_d        = mk_addr(row_q, col_q);
        data_wr_d     = bus.in_data;
        dp_load_d     = 1'b1;
        dp_pix_d      = bus.in_data;
        dp_line_end_d = (col_q == LAST_COL);
      end
      if (issue) begin
        ic_d       = ic_q + CNT_W'(1);
        dp_start_d = 1'b1;
        dp_col_d   = ic_q[COL_W-1:0];
      end
      if (res_ok) begin
        rc_d      = rc_q + CNT_W'(1);
        wen_d     = 1'b1;
        addr_d    = mk_addr(row_q, rc_q);
        data_wr_d = bus.dp_res;
      end
      if (issue && !res_ok)      outst_d = outst_q + 4'd1;
      else if (!issue && res_ok) outst_d = outst_q - 4'd1;
    end
    // Computed from the next column so req drops on the edge accepting the last pixel
    req_d  = (state_d == LOAD) && (col_d < W_CNT);
    done_d = (state_d == FIN);
    err_d  = bus.err | res_bad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q           <= '0;
      ic_q            <= '0;
      rc_q            <= '0;
      outst_q         <= '0;
      bus.req         <= 1'b0;
      bus.dp_load     <= 1'b0;
      bus.dp_pix      <= '0;
      bus.dp_line_end <= 1'b0;
      bus.dp_start    <= 1'b0;
      bus.dp_col      <= '0;
      bus.wen         <= 1'b0;
      bus.addr        <= '0;
      bus.data_wr     <= '0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      col_q           <= col_d;
      ic_q            <= ic_d;
      rc_q            <= rc_d;
      outst_q         <= outst_d;
      bus.req         <= req_d;
      bus.dp_load     <= dp_load_d;
      bus.dp_pix      <= dp_pix_d;
      bus.dp_line_end <= dp_line_end_d;
      bus.dp_start    <= dp_start_d;
      bus.dp_col      <= dp_col_d;
      bus.wen         <= wen_d;
      bus.addr        <= addr_d;
      bus.data_wr     <= data_wr_d;
      bus.done        <= done_d;
      bus.err         <= err_d;
    end
  end

`ifdef ELA_STALL_CNT_EN
  logic stall_inc;
  // Host starvation while requesting, or an issue held back by the outstanding limit
  assign stall_inc = (state_q != FIN) &&
                     ((bus.req && !bus.in_valid) ||
                      ((state_q == INTERP) && (ic_q < W_CNT) && (outst_q == MAX_O)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 bus.stall_cnt <= '0;
    else if (stall_inc && (bus.stall_cnt != 16'hFFFF)) bus.stall_cnt <= bus.stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_ela_row_sched.sv
module tb_ela_row_sched;
  localparam int IMG_W = 32;
  localparam int IMG_H = 31;
  localparam int NPIX  = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ela_row_sched_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();
  ela_row_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .MAX_OUTST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int ncmp = 0;
  int nfail = 0;

  // Controls owned by the directed sequence
  int lat, gap_at, gap_len, spur_cnt;
  // State owned by the environment process
  int cyc = 0;
  int hp, gap_used, gap_req_hi, spur_done;
  int q_col[$];
  int q_due[$];
  int n_start, n_res, max_ahead;
  int wr_cnt, last_addr, done_cyc, first_addr, first_data, r1_next, r1_bad, le_cnt, le_bad;
  int wcount[NPIX];
  int wcyc[NPIX];
  logic [7:0] mem[NPIX];

  function automatic logic [7:0] pix(input int h);
    return 8'((h * 37 + 11) & 255);
  endfunction

  function automatic logic [7:0] dpv(input int c);
    return 8'((c * 5 + 3) & 255);
  endfunction

  function automatic int mem_errs();
    int e = 0;
    for (int a = 0; a < NPIX; a++) begin
      int r = a / IMG_W;
      int c = a % IMG_W;
      logic [7:0] ex = (r % 2 == 0) ? pix((r / 2) * IMG_W + c) : dpv(c);
      if (mem[a] !== ex) e++;
    end
    return e;
  endfunction

  function automatic int dup_errs();
    int e = 0;
    for (int a = 0; a < NPIX; a++) if (wcount[a] != 1) e++;
    return e;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({bus.req, bus.dp_load, bus.dp_pix, bus.dp_line_end, bus.dp_start, bus.dp_col,
                bus.wen, bus.addr, bus.data_wr, bus.done, bus.err});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!bus.done && n < 8000) begin
      tick();
      n++;
    end
    chk(tag, 64'(bus.done), 64'd1);
  endtask

  // Host, datapath and write-monitor models, all evaluated away from the active edge
  always @(negedge clk) begin
    logic v;
    cyc++;
    if (rst) begin
      hp = 0; gap_used = 0; gap_req_hi = 0; spur_done = spur_cnt;
      q_col.delete(); q_due.delete();
      n_start = 0; n_res = 0; max_ahead = 0;
      wr_cnt = 0; last_addr = -1; done_cyc = -1; first_addr = -1; first_data = -1;
      r1_next = 32; r1_bad = 0; le_cnt = 0; le_bad = 0;
      for (int a = 0; a < NPIX; a++) begin
        wcount[a] = 0; wcyc[a] = 0; mem[a] = 8'h00;
      end
      bus.in_valid = 1'b0; bus.in_data = 8'h00;
      bus.dp_res_valid = 1'b0; bus.dp_res = 8'h00;
    end else begin
      if (bus.wen) begin
        wr_cnt++;
        last_addr = int'(bus.addr);
        if (wr_cnt == 1) begin
          first_addr = int'(bus.addr);
          first_data = int'(bus.data_wr);
        end
        if (int'(bus.addr) < NPIX) begin
          mem[bus.addr] = bus.data_wr;
          wcount[bus.addr]++;
          wcyc[bus.addr] = cyc;
        end
        if (bus.addr >= 32 && bus.addr < 64) begin
          if (int'(bus.addr) == r1_next) r1_next++;
          else r1_bad++;
        end
      end
      if (bus.dp_line_end) begin
        le_cnt++;
        if (!(bus.wen && bus.addr[4:0] == 5'd31)) le_bad++;
      end
      if (bus.done && done_cyc < 0) done_cyc = cyc;

      bus.dp_res_valid = 1'b0;
      if (spur_cnt != spur_done) begin
        bus.dp_res_valid = 1'b1;
        bus.dp_res = 8'hEE;
        spur_done = spur_cnt;
      end else if (q_due.size() > 0 && q_due[0] <= cyc) begin
        bus.dp_res_valid = 1'b1;
        bus.dp_res = dpv(q_col[0]);
        void'(q_due.pop_front());
        void'(q_col.pop_front());
        n_res++;
      end
      if (bus.dp_start) begin
        q_col.push_back(int'(bus.dp_col));
        q_due.push_back(cyc + lat);
        n_start++;
      end
      if (n_start - n_res > max_ahead) max_ahead = n_start - n_res;

      v = 1'b1;
      if (hp == gap_at && gap_used < gap_len) begin
        v = 1'b0;
        gap_used++;
        if (bus.req) gap_req_hi++;
      end
      bus.in_valid = v;
      bus.in_data = pix(hp);
      if (bus.req && v) hp++;
    end
  end

  initial begin
    int n;
    rst = 1'b1; lat = 1; gap_at = -1; gap_len = 0; spur_cnt = 0;
    #1;
    chk("reset_outs_async", outs(), 64'd0);
    repeat (3) tick();
    chk("reset_outs", outs(), 64'd0);

    // Run 1: continuous host, 1-cycle datapath
    rst = 1'b0;
    tick();
    chk("req_first", 64'(bus.req), 64'd1);
    wait_done("r1_done");
    chk("r1_writes", 64'(wr_cnt), 64'd992);
    chk("r1_mem", 64'(mem_errs()), 64'd0);
    chk("r1_once", 64'(dup_errs()), 64'd0);
    chk("r1_first_addr", 64'(first_addr), 64'd0);
    chk("r1_last_addr", 64'(last_addr), 64'd959);
    chk("r1_done_after_959", 64'(done_cyc - wcyc[959]), 64'd1);
    chk("r1_err", 64'(bus.err), 64'd0);
    chk("r1_line_end_cnt", 64'(le_cnt), 64'd16);
    chk("r1_line_end_pos", 64'(le_bad), 64'd0);
    chk("r1_fin_quiet", 64'({bus.req, bus.wen, bus.dp_start, bus.dp_load}), 64'd0);

    // Run 2: 3-cycle host gap at row 2 col 10, 10-cycle datapath
    rst = 1'b1; tick(); tick();
    lat = 10; gap_at = 42; gap_len = 3;
    rst = 1'b0;
    wait_done("r2_done");
    chk("r2_gap_req_high", 64'(gap_req_hi), 64'd3);
    chk("r2_gap_spacing", 64'(wcyc[74] - wcyc[73]), 64'd4);
    chk("r2_addr74_once", 64'(wcount[74]), 64'd1);
    chk("r2_addr74_data", 64'(mem[74]), 64'(pix(42)));
    chk("r2_row1_order_bad", 64'(r1_bad), 64'd0);
    chk("r2_row1_count", 64'(r1_next), 64'd64);
    chk("r2_max_ahead", 64'(max_ahead), 64'd4);
    chk("r2_writes", 64'(wr_cnt), 64'd992);
    chk("r2_mem", 64'(mem_errs()), 64'd0);

    // Run 3: spurious result during LOAD of row 0, 7-cycle host gap at row 6 col 4
    rst = 1'b1; tick(); tick();
    lat = 1; gap_at = 100; gap_len = 7;
    rst = 1'b0;
    n = 0;
    while (hp < 5 && n < 100) begin tick(); n++; end
    chk("r3_reached_row0", 64'(hp >= 5), 64'd1);
    spur_cnt++;
    tick(); tick();
    chk("r3_err_set", 64'(bus.err), 64'd1);
    wait_done("r3_done");
    chk("r3_err_sticky", 64'(bus.err), 64'd1);
    chk("r3_writes", 64'(wr_cnt), 64'd992);
    chk("r3_mem", 64'(mem_errs()), 64'd0);
`ifdef ELA_STALL_CNT_EN
    chk("r3_stall_cnt", 64'(bus.stall_cnt), 64'd7);
`endif

    // Run 4: reset during INTERP of row 5, then full frame restart
    rst = 1'b1; tick(); tick();
    lat = 1; gap_at = -1; gap_len = 0;
    rst = 1'b0;
    n = 0;
    while (wcount[165] == 0 && n < 3000) begin tick(); n++; end
    chk("r4_in_row5", 64'(wcount[165]), 64'd1);
    rst = 1'b1;
    #1;
    chk("r4_reset_now", outs(), 64'd0);
    tick();
    chk("r4_reset_next", outs(), 64'd0);
    rst = 1'b0;
    tick();
    chk("r4_req_restart", 64'(bus.req), 64'd1);
    n = 0;
    while (wr_cnt == 0 && n < 50) begin tick(); n++; end
    chk("r4_first_addr", 64'(first_addr), 64'd0);
    chk("r4_first_data", 64'(first_data), 64'(pix(0)));
    wait_done("r4_done");
    chk("r4_writes", 64'(wr_cnt), 64'd992);
    chk("r4_err", 64'(bus.err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
